// File: rtl/hex_nibble_loader.sv
// rtl/hex_nibble_loader.sv - ASCII hex UART stream loader for a one-hot nibble register bank
// Optional LOAD inter-character timeout is enabled by defining HEX_LOADER_TIMEOUT_EN.
module hex_nibble_loader #(
  parameter int NIBBLES     = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         done_ack,
  output logic [3:0]                   nib_out,
  output logic [NIBBLES-1:0]           nib_enb,
  output logic                         word_done,
  output logic                         busy,
  output logic [$clog2(NIBBLES+1)-1:0] nib_cnt,
  output logic                         err,
  output logic                         overrun
);

  localparam int CW = $clog2(NIBBLES+1);
  localparam logic [NIBBLES-1:0] MSB_ONEHOT = {1'b1, {(NIBBLES-1){1'b0}}};

  typedef logic [3:0] nibble_t;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      cnt_d;
  logic [NIBBLES-1:0] enb_d;
  nibble_t            nib_d;
  nibble_t            hex_val;
  logic               err_d, ovr_d, is_hex, is_esc, tmo;

  always_comb begin
    is_hex  = 1'b0;
    is_esc  = 1'b0;
    hex_val = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so +9 lands on 10.
      is_hex  = 1'b1;
      hex_val = rx_data[3:0] + 4'd9;
    end else if (rx_data == 8'h1B) begin
      is_esc  = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = nib_cnt;
    enb_d   = '0;
    nib_d   = nib_out;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && is_hex) begin
          enb_d   = MSB_ONEHOT;
          nib_d   = hex_val;
          cnt_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          if (is_hex) begin
            enb_d = MSB_ONEHOT >> nib_cnt;
            nib_d = hex_val;
            cnt_d = nib_cnt + CW'(1);
            if (nib_cnt == CW'(NIBBLES-1))
              state_d = WAIT_ACK;
          end else begin
            cnt_d   = '0;
            err_d   = !is_esc;
            state_d = IDLE;
          end
        end else if (tmo) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        // Characters are dropped here even when the ack arrives in the same cycle.
        ovr_d = rx_valid;
        if (done_ack) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HEX_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] tmo_cnt;

  assign tmo = (state == LOAD) && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tmo_cnt <= '0;
    else if (state_d != LOAD || rx_valid)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  // LOAD never times out in this build.
  assign tmo = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      nib_cnt   <= '0;
      nib_enb   <= '0;
      nib_out   <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_d;
      nib_cnt   <= cnt_d;
      nib_enb   <= enb_d;
      nib_out   <= nib_d;
      err       <= err_d;
      overrun   <= ovr_d;
      busy      <= (state_d == LOAD);
      // One cycle behind the last write so the bank has captured it.
      word_done <= (state == WAIT_ACK) && (state_d == WAIT_ACK);
    end
  end

endmodule

// File: tb/tb_hex_nibble_loader.sv
// tb/tb_hex_nibble_loader.sv - self-checking bench for hex_nibble_loader
// Timeout steps are exercised when HEX_LOADER_TIMEOUT_EN is defined.
module tb_hex_nibble_loader;

  localparam int N   = 4;
  localparam int CW  = $clog2(N+1);
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid, done_ack;
  logic [3:0]    nib_out;
  logic [N-1:0]  nib_enb;
  logic          word_done, busy, err, overrun;
  logic [CW-1:0] nib_cnt;

  int errors = 0;
  int checks = 0;

  hex_nibble_loader #(.NIBBLES(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .done_ack(done_ack),
    .nib_out(nib_out), .nib_enb(nib_enb), .word_done(word_done), .busy(busy),
    .nib_cnt(nib_cnt), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // External nibble register bank driven by the DUT.
  logic [3:0] bank [N];
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (nib_enb[i]) bank[i] <= nib_out;

  // Reference model: nibbles collected so far in the current word.
  int         m_len   = 0;
  bit         m_full  = 0;
  int         m_quiet = 0;
  logic [3:0] m_nib   = 4'd0;
  logic [3:0] m_word [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hexval(input logic [7:0] c, output logic [3:0] n);
    n = 4'd0;
    if (c >= 8'h30 && c <= 8'h39) begin n = 4'(c - 8'h30); return 1'b1; end
    if (c >= 8'h41 && c <= 8'h46) begin n = 4'(c - 8'h37); return 1'b1; end
    if (c >= 8'h61 && c <= 8'h66) begin n = 4'(c - 8'h57); return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [4*N-1:0] pack_bank();
    logic [4*N-1:0] w = '0;
    for (int i = 0; i < N; i++) w[4*i +: 4] = bank[i];
    return w;
  endfunction

  task automatic cyc(input bit v, input logic [7:0] d, input bit ack);
    logic [N-1:0] e_enb;
    logic [3:0]   n;
    bit           e_err, e_ovr, was_full;
    logic [4*N-1:0] w;
    rx_valid = v; rx_data = d; done_ack = ack;
    @(posedge clk); #1;
    e_enb = '0; e_err = 0; e_ovr = 0; was_full = m_full;
    if (m_full) begin
      e_ovr = v;
      if (ack) begin m_full = 0; m_len = 0; end
    end else if (v) begin
      m_quiet = 0;
      if (hexval(d, n)) begin
        e_enb = N'(1) << (N - 1 - m_len);
        m_nib = n;
        m_word[N-1-m_len] = n;
        m_len++;
        if (m_len == N) m_full = 1;
      end else if (m_len > 0) begin
        e_err = (d != 8'h1B);
        m_len = 0;
      end
    end else if (m_len > 0) begin
`ifdef HEX_LOADER_TIMEOUT_EN
      m_quiet++;
      if (m_quiet == TMO) begin e_err = 1; m_len = 0; m_quiet = 0; end
`endif
    end
    if (m_len == 0 || m_full) m_quiet = 0;
    chk("nib_enb", 32'(nib_enb), 32'(e_enb));
    chk("nib_out", 32'(nib_out), 32'(m_nib));
    chk("err", 32'(err), 32'(e_err));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    chk("nib_cnt", 32'(nib_cnt), 32'(m_len));
    chk("busy", 32'(busy), 32'(m_len > 0 && !m_full));
    chk("word_done", 32'(word_done), 32'(was_full && m_full));
    if (was_full && m_full) begin
      w = '0;
      for (int i = 0; i < N; i++) w[4*i +: 4] = m_word[i];
      chk("bank_word", 32'(pack_bank()), 32'(w));
    end
    rx_valid = 0; done_ack = 0;
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      cyc(1'b1, s[i], 1'b0);
      repeat (gap) cyc(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_nib_out"}, 32'(nib_out), 32'h0);
    chk({tag, "_nib_enb"}, 32'(nib_enb), 32'h0);
    chk({tag, "_word_done"}, 32'(word_done), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_nib_cnt"}, 32'(nib_cnt), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  string hexchars = "0123456789ABCDEFabcdef";

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; done_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Slow word "1aF9"
    send("1aF9", 9);
    cyc(1'b0, 8'h00, 1'b0);
    chk("word_1AF9", 32'(pack_bank()), 32'h1AF9);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ack_word_done", 32'(word_done), 32'h0);

    // Back-to-back
    send("1aF9", 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("b2b_word", 32'(pack_bank()), 32'h1AF9);
    cyc(1'b0, 8'h00, 1'b1);

    // Invalid char in LOAD, then a clean word
    send("3G", 0);
    chk("G_cnt", 32'(nib_cnt), 32'h0);
    send("5678", 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("word_5678", 32'(pack_bank()), 32'h5678);
    cyc(1'b0, 8'h00, 1'b1);

    // ESC abort, then word
    send("2", 0);
    cyc(1'b1, 8'h1B, 1'b0);
    send("4321", 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("word_4321", 32'(pack_bank()), 32'h4321);

    // Char together with ack while word is complete
    cyc(1'b1, 8'h37, 1'b1);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_enb", 32'(nib_enb), 32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovr_word_done", 32'(word_done), 32'h0);

    // Idle in LOAD
    send("1", 0);
    repeat (TMO - 1) cyc(1'b0, 8'h00, 1'b0);
    chk("quiet_busy", 32'(busy), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
`ifdef HEX_LOADER_TIMEOUT_EN
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_cnt", 32'(nib_cnt), 32'h0);
`else
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    chk("no_tmo_busy", 32'(busy), 32'h1);
    chk("no_tmo_cnt", 32'(nib_cnt), 32'h1);
    cyc(1'b1, 8'h1B, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] c;
      r = int'($urandom_range(0, 9));
      if (r == 6)      c = 8'h1B;
      else if (r == 7) c = 8'($urandom_range(0, 255));
      else             c = hexchars[$urandom_range(0, hexchars.len() - 1)];
      cyc(($urandom_range(0, 1) == 1), c, ($urandom_range(0, 3) == 0));
    end
    cyc(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a word
    send("9e", 0);
    rst = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    #2;
    rst = 1'b1;
    m_len = 0; m_full = 0; m_quiet = 0; m_nib = 4'd0;
    cyc(1'b0, 8'h00, 1'b0);
    send("c0de", 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("word_C0DE", 32'(pack_bank()), 32'hC0DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
